// File: rtl/easy_fifo_rd2axis.sv
// ---------------------------------------------------------------------------
// easy_fifo_rd2axis
//   Reader end of a native FIFO read port. Issues fifo_rd_en against a credit
//   window, captures the read data that returns RD_LATENCY cycles later into a
//   small circular prefetch buffer, and presents the buffer head as an
//   AXI-Stream master. Sustains one beat per cycle; fifo_rd_en has no
//   combinational dependence on m_axis_tready.
//
// Parameters
//   DWIDTH      data width in bits
//   RD_LATENCY  cycles from fifo_rd_en high to fifo_rd_data valid (1..4)
//   BUF_DEPTH   prefetch buffer entries, RD_LATENCY+2 (derived)
//
// Ports
//   clk            clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   fifo_rd_en     read strobe to the FIFO
//   fifo_rd_data   FIFO read data, valid RD_LATENCY cycles after fifo_rd_en
//   fifo_rd_empty  FIFO empty flag
//   m_axis_tdata   output beat
//   m_axis_tvalid  output beat valid
//   m_axis_tready  downstream ready
//   level          entries currently held in the prefetch buffer
// ---------------------------------------------------------------------------
module easy_fifo_rd2axis #(
    parameter int  DWIDTH     = 32,
    parameter int  RD_LATENCY = 1,
    localparam int BUF_DEPTH  = RD_LATENCY + 2,
    localparam int LVL_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [LVL_W-1:0]  level
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + RD_LATENCY + 1);

    typedef logic [PTR_W-1:0] ptr_t;

    // Pointers wrap explicitly so a non-power-of-2 depth works.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [DWIDTH-1:0]     mem_q [BUF_DEPTH];
    logic [DWIDTH-1:0]     mem_d [BUF_DEPTH];
    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;

    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      credit_used;
    logic                  capture;
    logic                  pop;

    // Credit: buffered entries plus reads still in the return pipe. Both terms
    // come from flops, so tready never reaches fifo_rd_en combinationally.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CNT_W'(vld_pipe_q[i]);
        end
        credit_used = CNT_W'(level_q) + inflight;
        fifo_rd_en  = rst_n & ~fifo_rd_empty & (credit_used < CNT_W'(BUF_DEPTH));
    end

    assign capture       = vld_pipe_q[RD_LATENCY-1];
    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign level         = level_q;

    // Return pipe: one bit per issued read, tail marks data on fifo_rd_data.
    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = fifo_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
    end

    // Captured data only becomes visible the cycle after capture (no bypass).
    always_comb begin
        mem_d = mem_q;
        if (capture) begin
            mem_d[wr_ptr_q] = fifo_rd_data;
        end
    end

    always_comb begin
        wr_ptr_d = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop     ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        level_d  = level_q;
        if (capture && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!capture && pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            vld_pipe_q <= vld_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_easy_fifo_rd2axis.sv
// ---------------------------------------------------------------------------
// tb_easy_fifo_rd2axis
//   Four instances of easy_fifo_rd2axis with RD_LATENCY 1..4 (lane l has
//   latency l+1, buffer depth l+3). Each lane is fed by a queue-based FIFO
//   model that returns popped words after the lane's latency. The reference
//   rule: every word popped from the FIFO leaves on AXIS exactly once, in pop
//   order, except words dropped by a reset.
// ---------------------------------------------------------------------------
module tb_easy_fifo_rd2axis;

    localparam int NL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NL-1:0]        rd_en, empty, tvalid, tready;
    logic [NL-1:0][31:0]  rd_data, tdata;
    logic [2:0]           lvl [NL];

    for (genvar gi = 0; gi < NL; gi++) begin : g_dut
        localparam int LW = $clog2(gi + 4);
        logic [LW-1:0] lvl_w;
        easy_fifo_rd2axis #(.DWIDTH(32), .RD_LATENCY(gi + 1)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .fifo_rd_en    (rd_en[gi]),
            .fifo_rd_data  (rd_data[gi]),
            .fifo_rd_empty (empty[gi]),
            .m_axis_tdata  (tdata[gi]),
            .m_axis_tvalid (tvalid[gi]),
            .m_axis_tready (tready[gi]),
            .level         (lvl_w)
        );
        assign lvl[gi] = 3'(lvl_w);
    end

    // FIFO model and scoreboard state
    logic [31:0] fq     [NL][$];
    logic [31:0] exp_q  [NL][$];
    logic [31:0] dpipe  [NL][4];
    bit          force_empty [NL];
    bit          hold_prev   [NL];
    logic [31:0] hold_data   [NL];
    int rd_cnt [NL], beat_cnt [NL], first_rd [NL], first_vld [NL];
    int last_beat [NL], gaps [NL];
    logic [31:0] first_data [NL];
    int cyc, n_checks, n_errors;

    task automatic reset_stats(input int l);
        rd_cnt[l] = 0; beat_cnt[l] = 0; first_rd[l] = -1; first_vld[l] = -1;
        last_beat[l] = -1; gaps[l] = 0; first_data[l] = '0;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        for (int l = 0; l < NL; l++) begin
            exp_q[l].delete();
            hold_prev[l] = 1'b0;
        end
    endtask

    // One clock cycle: settle, sample/check before the edge, then advance the
    // FIFO model 1ns after the edge.
    task automatic step();
        logic [NL-1:0] fire;
        logic [31:0]   w;
        for (int l = 0; l < NL; l++) empty[l] = (fq[l].size() == 0) || force_empty[l];
        #1;
        for (int l = 0; l < NL; l++) begin
            fire[l] = rd_en[l] && (fq[l].size() != 0);
            n_checks++;
            if (rd_en[l] && empty[l]) begin
                n_errors++;
                $display("FAIL rd_en_while_empty lane%0d: rd_en=%b empty=%b, required rd_en=0", l, rd_en[l], empty[l]);
            end
            n_checks++;
            if (int'(lvl[l]) > l + 3) begin
                n_errors++;
                $display("FAIL level_bound lane%0d: level=%0d, required <= %0d", l, lvl[l], l + 3);
            end
            n_checks++;
            if (tvalid[l] !== (lvl[l] != 3'd0)) begin
                n_errors++;
                $display("FAIL tvalid_vs_level lane%0d: tvalid=%b level=%0d", l, tvalid[l], lvl[l]);
            end
            if (hold_prev[l]) begin
                n_checks++;
                if (tvalid[l] !== 1'b1 || tdata[l] !== hold_data[l]) begin
                    n_errors++;
                    $display("FAIL axis_stable lane%0d: tvalid=%b tdata=%h, required 1/%h", l, tvalid[l], tdata[l], hold_data[l]);
                end
            end
            if (rd_en[l] === 1'b1) begin
                rd_cnt[l]++;
                if (first_rd[l] < 0) first_rd[l] = cyc;
            end
            if (tvalid[l] === 1'b1 && first_vld[l] < 0) first_vld[l] = cyc;
            if (tvalid[l] === 1'b1 && tready[l] === 1'b1) begin
                n_checks++;
                if (exp_q[l].size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_beat lane%0d: got %h, required no beat", l, tdata[l]);
                end else begin
                    w = exp_q[l].pop_front();
                    if (tdata[l] !== w) begin
                        n_errors++;
                        $display("FAIL beat_data lane%0d: got %h, required %h", l, tdata[l], w);
                    end
                end
                if (beat_cnt[l] == 0) first_data[l] = tdata[l];
                if (last_beat[l] >= 0 && cyc != last_beat[l] + 1) gaps[l]++;
                last_beat[l] = cyc;
                beat_cnt[l]++;
            end
            hold_prev[l] = (tvalid[l] === 1'b1) && (tready[l] === 1'b0);
            hold_data[l] = tdata[l];
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int l = 0; l < NL; l++) begin
            for (int i = 3; i > 0; i--) dpipe[l][i] = dpipe[l][i-1];
            if (fire[l]) begin
                w = fq[l].pop_front();
                exp_q[l].push_back(w);
                dpipe[l][0] = w;
            end else begin
                dpipe[l][0] = $urandom();
            end
            rd_data[l] = dpipe[l][l];
        end
    endtask

    task automatic test_reset();
        assert_reset();
        for (int l = 0; l < NL; l++) begin
            reset_stats(l);
            for (int k = 0; k < 3; k++) fq[l].push_back(32'h5000 + 32'(k));
        end
        for (int k = 0; k < 5; k++) begin
            step();
            for (int l = 0; l < NL; l++) begin
                n_checks++;
                if (rd_en[l] !== 1'b0 || tvalid[l] !== 1'b0 || tdata[l] !== 32'h0 || lvl[l] !== 3'd0) begin
                    n_errors++;
                    $display("FAIL reset_state lane%0d: rd_en=%b tvalid=%b tdata=%h level=%0d, required all 0",
                             l, rd_en[l], tvalid[l], tdata[l], lvl[l]);
                end
            end
        end
        for (int l = 0; l < NL; l++) fq[l].delete();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step();
        for (int l = 0; l < NL; l++) begin
            n_checks++;
            if (rd_cnt[l] != 0 || beat_cnt[l] != 0) begin
                n_errors++;
                $display("FAIL reset_idle lane%0d: reads=%0d beats=%0d, required 0/0", l, rd_cnt[l], beat_cnt[l]);
            end
        end
    endtask

    task automatic test_stream();
        reset_stats(0);
        for (int k = 0; k < 16; k++) fq[0].push_back(32'h10 + 32'(k));
        tready[0] = 1'b1;
        for (int k = 0; k < 60 && beat_cnt[0] < 16; k++) step();
        for (int k = 0; k < 3; k++) step();
        n_checks++;
        if (first_vld[0] - first_rd[0] != 2) begin
            n_errors++;
            $display("FAIL stream_latency: got %0d cycles, required 2", first_vld[0] - first_rd[0]);
        end
        n_checks++;
        if (beat_cnt[0] != 16 || gaps[0] != 0 || first_data[0] !== 32'h10) begin
            n_errors++;
            $display("FAIL stream_beats: beats=%0d gaps=%0d first=%h, required 16/0/10", beat_cnt[0], gaps[0], first_data[0]);
        end
        n_checks++;
        if (tvalid[0] !== 1'b0 || exp_q[0].size() != 0) begin
            n_errors++;
            $display("FAIL stream_end: tvalid=%b pending=%0d, required 0/0", tvalid[0], exp_q[0].size());
        end
    endtask

    task automatic test_backpressure();
        reset_stats(1);
        for (int k = 0; k < 8; k++) fq[1].push_back(32'hA0 + 32'(k));
        tready[1] = 1'b0;
        for (int k = 0; k < 20; k++) step();
        n_checks++;
        if (rd_cnt[1] != 4 || lvl[1] !== 3'd4) begin
            n_errors++;
            $display("FAIL bp_fill: reads=%0d level=%0d, required 4/4", rd_cnt[1], lvl[1]);
        end
        n_checks++;
        if (tvalid[1] !== 1'b1 || tdata[1] !== 32'hA0) begin
            n_errors++;
            $display("FAIL bp_head: tvalid=%b tdata=%h, required 1/a0", tvalid[1], tdata[1]);
        end
        tready[1] = 1'b1;
        for (int k = 0; k < 40 && beat_cnt[1] < 8; k++) step();
        n_checks++;
        if (beat_cnt[1] != 8 || gaps[1] != 0 || exp_q[1].size() != 0) begin
            n_errors++;
            $display("FAIL bp_drain: beats=%0d gaps=%0d pending=%0d, required 8/0/0", beat_cnt[1], gaps[1], exp_q[1].size());
        end
    endtask

    task automatic test_sparse();
        reset_stats(2);
        for (int k = 0; k < 20; k++) fq[2].push_back($urandom());
        tready[2] = 1'b1;
        for (int k = 0; k < 200 && beat_cnt[2] < 20; k++) begin
            force_empty[2] = ~force_empty[2];
            step();
        end
        force_empty[2] = 1'b0;
        n_checks++;
        if (beat_cnt[2] != 20 || rd_cnt[2] != 20 || fq[2].size() != 0) begin
            n_errors++;
            $display("FAIL sparse_count: beats=%0d reads=%0d left=%0d, required 20/20/0", beat_cnt[2], rd_cnt[2], fq[2].size());
        end
    endtask

    task automatic test_random();
        bit done;
        for (int l = 0; l < NL; l++) begin
            reset_stats(l);
            for (int k = 0; k < 1000; k++) fq[l].push_back($urandom());
        end
        done = 1'b0;
        for (int k = 0; k < 8000 && !done; k++) begin
            for (int l = 0; l < NL; l++) begin
                tready[l]      = 1'($urandom_range(0, 1));
                force_empty[l] = ($urandom_range(0, 3) == 0);
            end
            step();
            done = 1'b1;
            for (int l = 0; l < NL; l++) if (beat_cnt[l] < 1000) done = 1'b0;
        end
        for (int l = 0; l < NL; l++) begin
            tready[l] = 1'b1;
            force_empty[l] = 1'b0;
        end
        for (int k = 0; k < 10; k++) step();
        for (int l = 0; l < NL; l++) begin
            n_checks++;
            if (beat_cnt[l] != 1000 || exp_q[l].size() != 0 || fq[l].size() != 0) begin
                n_errors++;
                $display("FAIL random_total lane%0d: beats=%0d pending=%0d left=%0d, required 1000/0/0",
                         l, beat_cnt[l], exp_q[l].size(), fq[l].size());
            end
        end
    endtask

    task automatic test_midreset();
        reset_stats(1);
        for (int k = 0; k < 10; k++) fq[1].push_back(32'hB0 + 32'(k));
        tready[1] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        n_checks++;
        if (rd_cnt[1] != 3 || beat_cnt[1] != 0) begin
            n_errors++;
            $display("FAIL midrst_setup: reads=%0d beats=%0d, required 3/0", rd_cnt[1], beat_cnt[1]);
        end
        assert_reset();
        #1;
        n_checks++;
        if (tvalid[1] !== 1'b0 || lvl[1] !== 3'd0 || rd_en[1] !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_async: tvalid=%b level=%0d rd_en=%b, required 0/0/0", tvalid[1], lvl[1], rd_en[1]);
        end
        step();
        reset_stats(1);
        rst_n = 1'b1;
        for (int k = 0; k < 60 && beat_cnt[1] < 7; k++) step();
        for (int k = 0; k < 6; k++) step();
        n_checks++;
        if (beat_cnt[1] != 7 || first_data[1] !== 32'hB3 || exp_q[1].size() != 0) begin
            n_errors++;
            $display("FAIL midrst_resume: beats=%0d first=%h pending=%0d, required 7/b3/0",
                     beat_cnt[1], first_data[1], exp_q[1].size());
        end
    endtask

    initial begin
        rst_n = 1'b1;
        tready = '0;
        empty = '1;
        rd_data = '0;
        cyc = 0; n_checks = 0; n_errors = 0;
        for (int l = 0; l < NL; l++) begin
            force_empty[l] = 1'b0;
            hold_prev[l] = 1'b0;
            hold_data[l] = '0;
            for (int i = 0; i < 4; i++) dpipe[l][i] = '0;
            reset_stats(l);
        end
        #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_sparse();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
